nco_sine_core: RTL and testbench
================================

Name: nco_sine_core

Overview:
- Time-multiplexed numerically-controlled oscillator bank with sine waveshaper for the synth engine.
- Holds one 24-bit phase accumulator per (voice, oscillator) slot, advancing the addressed slot once per clock.
- Adds per-oscillator phase offset and modulation to the phase, then converts the 11-bit phase to a 17-bit signed sine sample through a quarter-wave ROM.
- Sits between the pitch/envelope scheduler and the voice mixer.

Parameters:
- VOICES, 8, number of voices.
- V_OSC, 8, oscillators per voice.
- V_WIDTH, 3, voice index width (log2 VOICES).
- O_WIDTH, 3, oscillator index width (log2 V_OSC).
- O_ENVS, 2, envelopes per oscillator; sets the osc_accum_zero width.

Ports:
- sCLK_XVXOSC, in, 1, the only clock; all logic on the rising edge.
- reset, in, 1, synchronous, active-high.
- vx, in, V_WIDTH, voice index of the current slot.
- ox, in, O_WIDTH, oscillator index of the current slot.
- osc_pitch_val, in, 24, unsigned phase increment for the current slot.
- osc_accum_zero, in, O_ENVS*V_OSC, per-envelope phase-reset requests for the current voice.
- modulation, in, 11 signed, phase modulation aligned to phase_acc.
- phase_offset, in, 8 signed, oscillator phase offset aligned to phase_acc.
- phase_acc, out, 11 signed, updated accumulator bits [23:13].
- sine_out, out, 17 signed, sine sample.

Behaviour:
- Accumulator array acc[VOICES*V_OSC], 24 bits unsigned. Slot index = {vx, ox}.
- Cycle c: slot inputs are presented. At the edge ending c:
  - acc[slot] <= osc_accum_zero[ox*O_ENVS] ? 0 : acc[slot] + osc_pitch_val (mod 2^24).
  - phase_acc <= that same new value, bits [23:13].
- The next update of a slot must see the value written for that slot, including the same slot on back-to-back cycles.
- Cycle c+1:
  - addr = phase_acc + modulation + (phase_offset << 3), computed in 11 bits with wraparound.
  - addr is registered at the edge ending c+1.
- Edge ending c+2: sine_out <= S(addr).
- Latency from slot inputs to sine_out is 3 clocks. The pipeline is fully pipelined, accepting one slot per clock with no stall or handshake.
- S(a) = round(65535 * sin(2π(a+0.5)/2048)), range ±65535.
- Quarter table Q[i] = round(65535 * sin(π(i+0.5)/1024)), i = 0..511, 16-bit unsigned. Decoding uses q = a[10:9] and i = a[8:0]:
  - q=0: +Q[i]
  - q=1: +Q[~i]
  - q=2: −Q[i]
  - q=3: −Q[~i]
- Negation is two's complement into 17 bits.
- Reset: all accumulators, phase_acc, the address register and sine_out clear to 0 at the first clock edge with reset high.
  - A mid-stream reset discards in-flight samples.
  - After reset deasserts, the first valid sine_out appears 3 clocks after the first slot is presented.
- While reset is high, writes to the accumulator array are suppressed.
- pitch = 0 holds phase. Accumulator overflow wraps silently.

Optional Feature:
- Macro SINE_FULL_TABLE_EN.
- When defined: sine_out comes from a full 2048-entry, 17-bit ROM holding S(a) directly, with no quadrant folding. Latency and values are identical.
- When undefined: the 512-entry quarter-wave ROM plus fold/negate logic is used.
- Both builds must be bit-exact.

Decomposition:
- Shared package nco_pkg holds:
  - PHASE_W = 11, ACC_W = 24, SINE_W = 17, QTR_DEPTH = 512.
  - typedefs phase_t (signed 11), acc_t (24), sample_t (signed 17).
  - function sine_q(i) used for ROM initialisation.
- One sub-module, sine_quarter_rom: registered-address-in, registered-sample-out waveshaper containing both ROM variants.

Test Plan:
- Reset, then slot {0,0} with pitch=0x002000 for 4 consecutive cycles → phase_acc = 1,2,3,4; sine_out lags 2 further clocks: S(1)=302, S(2)=503, ….
- Direct addressing with modulation and offset zero, accumulators preloaded by pitch → addr 0→101, 511→65535, 512→65535, 1024→−101, 1535→−65535.
- Rotate 64 slots, each with a distinct pitch, for 3 passes → every slot's phase_acc equals 3·pitch[23:13]; no cross-slot corruption; same slot back-to-back accumulates twice.
- acc at 0xFFE000 plus pitch 0x004000 → wraps to 0x002000, phase_acc=1. Asserting osc_accum_zero[ox*2] → phase_acc=0 that cycle regardless of pitch.
- phase_acc=0, modulation=−1, phase_offset=−1 → addr = 0x7F7 (wrap), sine_out = S(2039).
- Assert reset mid-stream for 1 cycle → all outputs 0 the next cycle and every accumulator restarts from 0. Rerun the bench with SINE_FULL_TABLE_EN defined → identical sample trace.

Source files
------------

// File: rtl/nco_sine_core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : nco_pkg                                                        |
// | Purpose   : Shared widths, types and sine-table helpers for nco_sine_core  |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package nco_pkg;

  localparam int PHASE_W   = 11;
  localparam int ACC_W     = 24;
  localparam int SINE_W    = 17;
  localparam int QTR_DEPTH = 512;

  localparam real C_PI = 3.14159265358979323846;

  typedef logic signed [PHASE_W-1:0] phase_t;
  typedef logic        [ACC_W-1:0]   acc_t;
  typedef logic signed [SINE_W-1:0]  sample_t;

  // Quarter-wave magnitude Q[i] = round(65535*sin(pi*(i+0.5)/1024)).
  // Always positive, so round-half-up via +0.5 and truncation is exact.
  function automatic logic [15:0] sine_q(input int unsigned i);
    real x;
    x = 65535.0 * $sin(C_PI * (real'(i) + 0.5) / 1024.0);
    return 16'($rtoi(x + 0.5));
  endfunction

  // Full-wave sample S(a) built from the quarter table so that the full-table
  // ROM contents are identical, bit for bit, to the folded datapath.
  function automatic sample_t sine_full(input logic [PHASE_W-1:0] a);
    logic [8:0]  idx;
    logic [15:0] mag;
    sample_t     s;
    idx = a[9] ? ~a[8:0] : a[8:0];
    mag = sine_q(32'(idx));
    s   = sample_t'({1'b0, mag});
    return a[10] ? -s : s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nco_sine_core_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : nco_sine_core_if                                               |
// | Purpose   : Slot bus between scheduler (master) and NCO core (slave)       |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface nco_sine_core_if #(
  parameter int V_WIDTH = 3,
  parameter int O_WIDTH = 3,
  parameter int V_OSC   = 8,
  parameter int O_ENVS  = 2
);
  import nco_pkg::*;

  logic [V_WIDTH-1:0]      vx;
  logic [O_WIDTH-1:0]      ox;
  acc_t                    osc_pitch_val;
  logic [O_ENVS*V_OSC-1:0] osc_accum_zero;
  phase_t                  modulation;
  logic signed [7:0]       phase_offset;
  phase_t                  phase_acc;
  sample_t                 sine_out;

  modport master (
    output vx, ox, osc_pitch_val, osc_accum_zero, modulation, phase_offset,
    input  phase_acc, sine_out
  );

  modport slave (
    input  vx, ox, osc_pitch_val, osc_accum_zero, modulation, phase_offset,
    output phase_acc, sine_out
  );

endinterface
`default_nettype wire

// File: rtl/nco_sine_core_sine_quarter_rom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : sine_quarter_rom                                               |
// | Purpose   : Registered address in, registered 17-bit signed sine out.      |
// |             Default: 512-entry quarter-wave ROM with fold/negate.          |
// |             SINE_FULL_TABLE_EN: 2048-entry full-wave ROM, same values.     |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module sine_quarter_rom
  import nco_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [PHASE_W-1:0] addr_i,
  output sample_t            sample_o
);

  logic [PHASE_W-1:0] addr_q;
  sample_t            sample_d;
  sample_t            sample_q;

  // Address and sample pipeline registers; reset drops whatever is in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q   <= '0;
      sample_q <= '0;
    end else begin
      addr_q   <= addr_i;
      sample_q <= sample_d;
    end
  end

`ifdef SINE_FULL_TABLE_EN
  sample_t full_rom [2**PHASE_W];

  for (genvar a = 0; a < 2**PHASE_W; a++) begin : g_full_rom
    assign full_rom[a] = sine_full(PHASE_W'(a));
  end

  // Direct lookup, no folding.
  always_comb begin
    sample_d = full_rom[addr_q];
  end
`else
  logic [15:0] qtr_rom [QTR_DEPTH];
  logic [8:0]  idx_w;
  logic [15:0] mag_w;

  for (genvar i = 0; i < QTR_DEPTH; i++) begin : g_qtr_rom
    assign qtr_rom[i] = sine_q(i);
  end

  // Odd quadrants read the table mirrored; the upper half-wave is negated.
  always_comb begin
    idx_w    = addr_q[9] ? ~addr_q[8:0] : addr_q[8:0];
    mag_w    = qtr_rom[idx_w];
    sample_d = addr_q[10] ? -sample_t'({1'b0, mag_w}) : sample_t'({1'b0, mag_w});
  end
`endif

  assign sample_o = sample_q;

endmodule
`default_nettype wire

// File: rtl/nco_sine_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : nco_sine_core                                                  |
// | Purpose   : Time-multiplexed 64-slot NCO bank with sine waveshaper.        |
// |             Slot in -> phase_acc 1 clk -> address 2 clk -> sine 3 clk.     |
// |             Option macro SINE_FULL_TABLE_EN selects a full-wave ROM.       |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module nco_sine_core
  import nco_pkg::*;
#(
  parameter int VOICES  = 8,
  parameter int V_OSC   = 8,
  parameter int V_WIDTH = 3,
  parameter int O_WIDTH = 3,
  parameter int O_ENVS  = 2
) (
  input  logic                   sCLK_XVXOSC,
  input  logic                   reset,
  nco_sine_core_if.slave         bus
);

  localparam int SLOTS  = VOICES * V_OSC;
  localparam int ZBITS  = O_ENVS * V_OSC;
  localparam int ZIDX_W = $clog2(ZBITS);

  acc_t                       acc_q [SLOTS];
  logic [V_WIDTH+O_WIDTH-1:0] slot_w;
  logic [ZIDX_W-1:0]          zidx_w;
  logic                       zero_w;
  acc_t                       acc_d;
  phase_t                     phase_acc_q;
  logic [PHASE_W-1:0]         addr_d;

  // New accumulator value for the addressed slot; the first envelope bit of
  // the oscillator forces a phase reset.
  always_comb begin
    slot_w = {bus.vx, bus.ox};
    zidx_w = ZIDX_W'(bus.ox) * ZIDX_W'(O_ENVS);
    zero_w = bus.osc_accum_zero[zidx_w];
    acc_d  = zero_w ? '0 : acc_q[slot_w] + bus.osc_pitch_val;
  end

  // Accumulator array write-back and phase output; the array is read
  // combinationally, so a back-to-back hit on one slot sees the fresh value.
  always_ff @(posedge sCLK_XVXOSC) begin
    if (reset) begin
      for (int s = 0; s < SLOTS; s++) begin
        acc_q[s] <= '0;
      end
      phase_acc_q <= '0;
    end else begin
      acc_q[slot_w] <= acc_d;
      phase_acc_q   <= phase_t'(acc_d[ACC_W-1:ACC_W-PHASE_W]);
    end
  end

  // Table address: phase + modulation + offset scaled by 8, wrapping in 11 bits.
  always_comb begin
    addr_d = $unsigned(phase_acc_q) + $unsigned(bus.modulation)
           + {$unsigned(bus.phase_offset), 3'b000};
  end

  sine_quarter_rom u_rom (
    .clk_i    (sCLK_XVXOSC),
    .rst_i    (reset),
    .addr_i   (addr_d),
    .sample_o (bus.sine_out)
  );

  assign bus.phase_acc = phase_acc_q;

endmodule
`default_nettype wire

// File: tb/tb_nco_sine_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_nco_sine_core                                               |
// | Purpose   : Scoreboard bench for nco_sine_core                             |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_nco_sine_core;

  logic clk = 1'b0;
  logic reset;

  nco_sine_core_if bus ();

  nco_sine_core dut (
    .sCLK_XVXOSC (clk),
    .reset       (reset),
    .bus         (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int q_phase [$];
  int q_sine  [$];

  bit          issue    = 1'b0;
  logic [10:0] pend_mod = '0;
  logic [7:0]  pend_off = '0;
  bit   [2:0]  vp       = '0;
  bit          rst_s;

  // Reference sine straight from the full-wave definition.
  function automatic int s_model(input int a);
    real x;
    x = 65535.0 * $sin(2.0 * 3.14159265358979323846 * (real'(a) + 0.5) / 2048.0);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(-x + 0.5);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One slot per cycle; modulation/offset of a slot go out one cycle later.
  task automatic drive(input bit iss, input int v, input int o, input logic [23:0] pitch,
                       input logic [15:0] zero, input int md, input int off,
                       input int exp_ph, input int exp_s);
    bus.vx             = 3'(v);
    bus.ox             = 3'(o);
    bus.osc_pitch_val  = pitch;
    bus.osc_accum_zero = zero;
    bus.modulation     = pend_mod;
    bus.phase_offset   = pend_off;
    pend_mod           = 11'(md);
    pend_off           = 8'(off);
    issue              = iss;
    if (iss) begin
      q_phase.push_back(exp_ph);
      q_sine.push_back(exp_s);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 24'h0, 16'h0, 0, 0, 0, 0);
  endtask

  task automatic reset_dut(input int n);
    reset              = 1'b1;
    issue              = 1'b0;
    pend_mod           = '0;
    pend_off           = '0;
    bus.vx             = '0;
    bus.ox             = '0;
    bus.osc_pitch_val  = '0;
    bus.osc_accum_zero = '0;
    bus.modulation     = '0;
    bus.phase_offset   = '0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: phase_acc is due 1 edge after issue, sine_out 3 edges after.
  initial begin
    forever begin
      @(posedge clk);
      rst_s = reset;
      vp    = {vp[1:0], issue};
      if (rst_s) begin
        vp = '0;
        q_phase.delete();
        q_sine.delete();
      end
      #1;
      if (rst_s) begin
        check("reset_phase_acc", int'($unsigned(bus.phase_acc)), 0);
        check("reset_sine_out", int'(bus.sine_out), 0);
      end else begin
        if (vp[0]) begin
          if (q_phase.size() == 0) check("phase_queue_underflow", 1, 0);
          else check("phase_acc", int'($unsigned(bus.phase_acc)), q_phase.pop_front());
        end
        if (vp[2]) begin
          if (q_sine.size() == 0) check("sine_queue_underflow", 1, 0);
          else check("sine_out", int'(bus.sine_out), q_sine.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int inc;
    int ph;
    reset_dut(2);

    // Single slot stepping by one phase LSB.
    drive(1, 0, 0, 24'h002000, 16'h0, 0, 0, 1, 302);
    drive(1, 0, 0, 24'h002000, 16'h0, 0, 0, 2, 503);
    drive(1, 0, 0, 24'h002000, 16'h0, 0, 0, 3, 704);
    drive(1, 0, 0, 24'h002000, 16'h0, 0, 0, 4, 905);

    // Quadrant boundaries through fresh slots.
    drive(1, 1, 0, 24'h000000, 16'h0, 0, 0, 0,    101);
    drive(1, 1, 1, 24'h3FE000, 16'h0, 0, 0, 511,  65535);
    drive(1, 1, 2, 24'h400000, 16'h0, 0, 0, 512,  65535);
    drive(1, 1, 3, 24'h800000, 16'h0, 0, 0, 1024, -101);
    drive(1, 1, 4, 24'hBFE000, 16'h0, 0, 0, 1535, -65535);

    // Wraparound and phase-reset requests.
    drive(1, 2, 0, 24'hFFE000, 16'h0,    0, 0, 2047, -101);
    drive(1, 2, 0, 24'h004000, 16'h0,    0, 0, 1,    302);
    drive(1, 2, 0, 24'h123456, 16'h0001, 0, 0, 0,    101);
    drive(1, 2, 5, 24'h100000, 16'h0,    0, 0, 128,  s_model(128));
    drive(1, 2, 5, 24'h0AB000, 16'h0400, 0, 0, 0,    101);
    drive(1, 2, 6, 24'h002000, 16'h2000, 0, 0, 1,    302);
    drive(1, 2, 6, 24'h002000, 16'h0001, 0, 0, 2,    503);

    // Modulation and offset, including negative wrap to 0x7F7.
    drive(1, 3, 0, 24'h000000, 16'h0, -1, -1, 0,   -1709);
    drive(1, 3, 1, 24'h0C8000, 16'h0,  5,  2, 100, s_model(121));
    idle(4);

    // Mid-stream reset with samples in flight.
    drive(1, 0, 0, 24'h002000, 16'h0, 0, 0, 5, s_model(5));
    drive(1, 5, 5, 24'h002000, 16'h0, 0, 0, 1, 302);
    reset_dut(1);

    // Rotate all 64 slots for three passes; every slot must restart from 0.
    for (int p = 1; p <= 3; p++) begin
      for (int s = 0; s < 64; s++) begin
        inc = 3 * s + 1;
        ph  = (p * inc) % 2048;
        drive(1, s >> 3, s & 7, 24'((inc << 13) | (s * 16)), 16'h0, 0, 0, ph, s_model(ph));
      end
    end

    // Same slot on consecutive cycles accumulates twice.
    drive(1, 7, 7, 24'(((3 * 63 + 1) << 13) | (63 * 16)), 16'h0, 0, 0, 760, s_model(760));
    drive(1, 7, 7, 24'(((3 * 63 + 1) << 13) | (63 * 16)), 16'h0, 0, 0, 950, s_model(950));
    idle(5);

    check("scoreboard_drained", q_phase.size() + q_sine.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
